// File: rtl/mcu_io_pkg.sv
// Shared port map constants and register types for the mini-mcu I/O bank.
package mcu_io_pkg;

  typedef logic [7:0] port_id_t;

  localparam port_id_t IO_ID_OUT_BASE = 8'h00;
  localparam port_id_t IO_ID_IN       = 8'h10;
  localparam port_id_t IO_ID_EDGE     = 8'h11;
  localparam port_id_t IO_ID_STAT     = 8'h12;
  localparam port_id_t IO_ID_IRQEN    = 8'h13;
  localparam port_id_t IO_ID_EMASK    = 8'h14;

  localparam int IRQ_TICK_BIT = 0;
  localparam int IRQ_EDGE_BIT = 1;

  // Field order matches the register layout: edge_en is bit 1, tick_en is bit 0.
  typedef struct packed {
    logic edge_en;
    logic tick_en;
  } irq_en_t;

endpackage

// File: rtl/mcu_io_bank_debounce.sv
// One input bit: 2-FF synchroniser followed by a stability-window debouncer.
module io_debounce
  import mcu_io_pkg::*;
#(
  parameter int DEB_CNT = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  // Rise is flagged on the same edge that stable flips to 1.
  assign accept = (sync != stable) && (cnt == CNT_LAST);
  assign rise   = accept && sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcu_io_bank.sv
// Port-mapped I/O bank: output registers, debounced inputs, edge events, tick, interrupt.
// Optional tick generator is built only when MCU_IO_TICK_EN is defined.
module mcu_io_bank
  import mcu_io_pkg::*;
#(
  parameter int         N_OUT    = 4,
  parameter int         N_IN     = 8,
  parameter int         DEB_CNT  = 240000,
  parameter int         TICK_DIV = 12000000,
  parameter logic [7:0] OUT_RST  = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  output logic [7:0]         in_port,
  input  logic [N_IN-1:0]    pins_in,
  output logic [8*N_OUT-1:0] out_ports,
  output logic               interrupt
);

  logic [N_IN-1:0]       stable;
  logic [N_IN-1:0]       rise;
  logic [N_IN-1:0]       edge_pend;
  logic [N_IN-1:0]       edge_mask;
  logic [N_IN-1:0]       edge_clr;
  logic                  edge_any;
  irq_en_t               irq_en;
  logic [N_OUT-1:0][7:0] out_regs;
  logic                  tick_pend;
  logic [7:0]            read_data;
  logic                  wr_edge;
  logic                  wr_irqen;
  logic                  wr_emask;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_debounce #(
      .DEB_CNT (DEB_CNT)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .pin    (pins_in[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );
  end

  assign wr_edge  = write_strobe && (port_id == IO_ID_EDGE);
  assign wr_irqen = write_strobe && (port_id == IO_ID_IRQEN);
  assign wr_emask = write_strobe && (port_id == IO_ID_EMASK);

  assign out_ports = out_regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_regs <= {N_OUT{OUT_RST}};
    end else if (write_strobe) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (port_id == IO_ID_OUT_BASE + 8'(k)) begin
          out_regs[k] <= out_port;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en    <= '0;
      edge_mask <= '0;
    end else begin
      if (wr_irqen) begin
        irq_en <= irq_en_t'(out_port[1:0]);
      end
      if (wr_emask) begin
        edge_mask <= out_port[N_IN-1:0];
      end
    end
  end

  // The set term is OR-ed after the clear so a new event survives a same-cycle W1C.
  assign edge_clr = wr_edge ? out_port[N_IN-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_pend <= '0;
    end else begin
      edge_pend <= (edge_pend & ~edge_clr) | (rise & edge_mask);
    end
  end

  assign edge_any = |(edge_pend & edge_mask);

`ifdef MCU_IO_TICK_EN
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick_wrap;
  logic          wr_stat;

  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign wr_stat   = write_strobe && (port_id == IO_ID_STAT);

  // Free-running: register writes never disturb the tick phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      if (tick_wrap) begin
        tick_pend <= 1'b1;
      end else if (wr_stat && out_port[0]) begin
        tick_pend <= 1'b0;
      end
    end
  end
`else
  assign tick_pend = 1'b0;
`endif

  always_comb begin
    read_data = '0;
    case (port_id)
      IO_ID_IN:    read_data[N_IN-1:0] = stable;
      IO_ID_EDGE:  read_data[N_IN-1:0] = edge_pend;
      IO_ID_STAT:  read_data[1:0]      = {edge_any, tick_pend};
      IO_ID_IRQEN: read_data[1:0]      = irq_en;
      IO_ID_EMASK: read_data[N_IN-1:0] = edge_mask;
      default:     read_data           = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_port   <= 8'h00;
      interrupt <= 1'b0;
    end else begin
      in_port   <= read_data;
      interrupt <= (irq_en.tick_en & tick_pend) | (irq_en.edge_en & edge_any);
    end
  end

endmodule

// File: tb/tb_mcu_io_bank.sv
// Directed self-checking bench for mcu_io_bank (DEB_CNT=4, TICK_DIV=10, N_OUT=4, N_IN=8).
module tb_mcu_io_bank;

  localparam int N_OUT    = 4;
  localparam int N_IN     = 8;
  localparam int DEB_CNT  = 4;
  localparam int TICK_DIV = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         port_id;
  logic [7:0]         out_port;
  logic               write_strobe;
  logic [7:0]         in_port;
  logic [N_IN-1:0]    pins_in;
  logic [8*N_OUT-1:0] out_ports;
  logic               interrupt;

  int checks = 0;
  int errors = 0;

  mcu_io_bank #(
    .N_OUT    (N_OUT),
    .N_IN     (N_IN),
    .DEB_CNT  (DEB_CNT),
    .TICK_DIV (TICK_DIV),
    .OUT_RST  (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .in_port      (in_port),
    .pins_in      (pins_in),
    .out_ports    (out_ports),
    .interrupt    (interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_port(input logic [7:0] id, input logic [7:0] data);
    port_id      = id;
    out_port     = data;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic read_port(input logic [7:0] id, output logic [7:0] data);
    port_id = id;
    step();
    data = in_port;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    rst = 1'b1;
    #2;
    checks++;
    if (out_ports !== 32'h0 || in_port !== 8'h00 || interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got out=%h in=%h irq=%b expected 0/0/0", out_ports, in_port, interrupt);
    end
    step();
    step();
    rst = 1'b0;
    read_port(8'h13, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_irqen: got %h expected %h", rd, 8'h00);
    end
    read_port(8'h14, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_emask: got %h expected %h", rd, 8'h00);
    end
  endtask

  task automatic test_out_regs();
    logic [7:0] rd;
    write_port(8'h01, 8'hA5);
    checks++;
    if (out_ports !== 32'h0000A500) begin
      errors++;
      $display("[TB] FAIL out_write_01: got %h expected %h", out_ports, 32'h0000A500);
    end
    write_port(8'h07, 8'h3C);
    checks++;
    if (out_ports !== 32'h0000A500) begin
      errors++;
      $display("[TB] FAIL out_write_07_ignored: got %h expected %h", out_ports, 32'h0000A500);
    end
    write_port(8'h03, 8'h7E);
    checks++;
    if (out_ports !== 32'h7E00A500) begin
      errors++;
      $display("[TB] FAIL out_write_03: got %h expected %h", out_ports, 32'h7E00A500);
    end
    read_port(8'h07, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_07: got %h expected %h", rd, 8'h00);
    end
    read_port(8'h01, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_01_writeonly: got %h expected %h", rd, 8'h00);
    end
  endtask

  task automatic test_debounce();
    logic seen;
    port_id    = 8'h10;
    pins_in[0] = 1'b1;
    repeat (3) step();
    pins_in[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (in_port !== 8'h00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL deb_glitch_rejected: got change=%b expected %b", seen, 1'b0);
    end
    pins_in[0] = 1'b1;
    repeat (6) step();
    checks++;
    if (in_port !== 8'h00) begin
      errors++;
      $display("[TB] FAIL deb_not_yet: got %h expected %h", in_port, 8'h00);
    end
    step();
    checks++;
    if (in_port !== 8'h01) begin
      errors++;
      $display("[TB] FAIL deb_stable_high: got %h expected %h", in_port, 8'h01);
    end
  endtask

  task automatic test_edge_irq();
    logic [7:0] rd;
    pins_in[0] = 1'b0;
    repeat (10) step();
    write_port(8'h14, 8'h01);
    write_port(8'h13, 8'h02);
    read_port(8'h13, rd);
    checks++;
    if (rd !== 8'h02) begin
      errors++;
      $display("[TB] FAIL irqen_readback: got %h expected %h", rd, 8'h02);
    end
    port_id    = 8'h11;
    pins_in[0] = 1'b1;
    repeat (6) step();
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_irq_lag: got %b expected %b", interrupt, 1'b0);
    end
    step();
    checks++;
    if (in_port !== 8'h01 || interrupt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_pend_set: got pend=%h irq=%b expected 01/1", in_port, interrupt);
    end
    read_port(8'h12, rd);
    checks++;
    if ((rd & 8'hFE) !== 8'h02) begin
      errors++;
      $display("[TB] FAIL status_edge_bit: got %h expected %h", rd & 8'hFE, 8'h02);
    end
    write_port(8'h11, 8'h01);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL w1c_irq_lag: got %b expected %b", interrupt, 1'b1);
    end
    step();
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w1c_irq_drop: got %b expected %b", interrupt, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    pins_in[0] = 1'b0;
    repeat (10) step();
    pins_in[0] = 1'b1;
    repeat (5) step();
    write_port(8'h11, 8'h01);
    read_port(8'h11, rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("[TB] FAIL collision_set_wins: got %h expected %h", rd, 8'h01);
    end
    write_port(8'h14, 8'h00);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mask_clear_lag: got %b expected %b", interrupt, 1'b1);
    end
    read_port(8'h11, rd);
    checks++;
    if (rd !== 8'h01 || interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mask_clear_keeps_pend: got pend=%h irq=%b expected 01/0", rd, interrupt);
    end
    write_port(8'h11, 8'hFF);
    read_port(8'h11, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL pend_cleared: got %h expected %h", rd, 8'h00);
    end
  endtask

  task automatic test_tick();
`ifdef MCU_IO_TICK_EN
    int   rise_t[4];
    int   nr;
    logic prev;
    logic [7:0] rd;
    write_port(8'h13, 8'h01);
    nr   = 0;
    prev = interrupt;
    for (int c = 0; c < 70 && nr < 4; c++) begin
      if (interrupt) begin
        port_id      = 8'h12;
        out_port     = 8'h01;
        write_strobe = 1'b1;
      end else begin
        write_strobe = 1'b0;
      end
      step();
      if (interrupt && !prev) begin
        rise_t[nr] = c;
        nr++;
      end
      prev = interrupt;
    end
    write_strobe = 1'b0;
    checks++;
    if (nr != 4) begin
      errors++;
      $display("[TB] FAIL tick_rises: got %0d expected %0d", nr, 4);
    end else begin
      checks++;
      if (rise_t[2] - rise_t[1] != TICK_DIV || rise_t[3] - rise_t[2] != TICK_DIV) begin
        errors++;
        $display("[TB] FAIL tick_period: got %0d,%0d expected %0d", rise_t[2] - rise_t[1], rise_t[3] - rise_t[2], TICK_DIV);
      end
    end
    repeat (12) step();
    read_port(8'h12, rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("[TB] FAIL tick_status: got %h expected %h", rd, 8'h01);
    end
`else
    logic bad_rd;
    logic bad_irq;
    write_port(8'h13, 8'h01);
    write_port(8'h12, 8'h01);
    port_id = 8'h12;
    bad_rd  = 1'b0;
    bad_irq = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (in_port !== 8'h00) bad_rd = 1'b1;
      if (interrupt !== 1'b0) bad_irq = 1'b1;
    end
    checks++;
    if (bad_rd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL notick_status: got nonzero=%b expected %b", bad_rd, 1'b0);
    end
    checks++;
    if (bad_irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL notick_irq: got high=%b expected %b", bad_irq, 1'b0);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [7:0] rd;
    write_port(8'h13, 8'h02);
    write_port(8'h14, 8'h01);
    pins_in[0] = 1'b0;
    repeat (10) step();
    pins_in[0] = 1'b1;
    repeat (7) step();
    write_port(8'h02, 8'h5A);
    read_port(8'h11, rd);
    checks++;
    if (rd !== 8'h01 || interrupt !== 1'b1 || out_ports[23:16] !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL prereset_state: got pend=%h irq=%b out2=%h expected 01/1/5a", rd, interrupt, out_ports[23:16]);
    end
    pins_in[0] = 1'b0;
    repeat (3) step();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_ports !== 32'h0 || in_port !== 8'h00 || interrupt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got out=%h in=%h irq=%b expected 0/0/0", out_ports, in_port, interrupt);
    end
    step();
    step();
    rst = 1'b0;
    read_port(8'h11, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL postreset_pend: got %h expected %h", rd, 8'h00);
    end
    read_port(8'h10, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL postreset_stable: got %h expected %h", rd, 8'h00);
    end
  endtask

  initial begin
    rst          = 1'b1;
    port_id      = 8'h00;
    out_port     = 8'h00;
    write_strobe = 1'b0;
    pins_in      = '0;
    test_reset();
    test_out_regs();
    test_debounce();
    test_edge_irq();
    test_back_to_back();
    test_tick();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_io_bank.md
Name: mcu_io_bank

Overview:
Parametrised I/O peripheral for the mini-mcu port bus. It replaces hand-written port_id decoding in board top levels.
- Provides N_OUT write-only output registers.
- Samples N_IN asynchronous inputs through a synchroniser and debouncer, readable by the core.
- Latches rising-edge events into per-bit pending flags.
- Generates a periodic tick and drives the mcu interrupt line from enabled, pending sources.

Parameters:
N_OUT, 4, number of 8-bit output registers (1..16), port_id 0x00..N_OUT-1
N_IN, 8, number of external inputs (1..8)
DEB_CNT, 240000, debounce stability window in clk cycles (>=1); 20 ms at 12 MHz
TICK_DIV, 12000000, tick period in clk cycles (>=2)
OUT_RST, 8'h00, reset value of every output register

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
port_id  in  8  mcu port address
out_port  in  8  mcu write data
write_strobe  in  1  mcu write qualifier, one cycle
in_port  out  8  read data to mcu, registered
pins_in  in  N_IN  raw asynchronous inputs (keys/switches)
out_ports  out  8*N_OUT  output registers, port k at bits [8k+7:8k]
interrupt  out  1  level interrupt to mcu, registered

Behaviour:
- Reset: the following values apply asynchronously.
  - out_ports = {N_OUT{OUT_RST}}.
  - in_port = 0, interrupt = 0.
  - All sync flops, stable bits, debounce counters, pending flags, masks, enables and the tick counter = 0.
- Port map:
  - 0x00..N_OUT-1: W out reg.
  - 0x10: R debounced inputs (zero-extended).
  - 0x11: R edge_pend; W1C edge_pend.
  - 0x12: R {6'b0, |edge_pend_masked, tick_pend}; W1C bit0 = tick_pend.
  - 0x13: R/W irq_en {bit1 edge_en, bit0 tick_en}.
  - 0x14: R/W edge_mask[N_IN-1:0].
- Writes: take effect on the clk edge where write_strobe=1. Writes to unmapped IDs, or to out-reg IDs >= N_OUT, are ignored.
- Reads: in_port <= mux(port_id) every cycle, so data appears 1 cycle after port_id. read_strobe is not needed; reads have no side effects. Unmapped IDs read 0x00.
- Input path (per bit):
  - 2-FF synchroniser produces sync.
  - While sync != stable, the counter increments. When the counter reaches DEB_CNT-1 with sync still != stable: stable <= sync, counter <= 0.
  - If sync == stable, the counter clears. Any glitch shorter than DEB_CNT cycles is rejected.
  - Latency from a pin change to stable = 2 + DEB_CNT cycles.
- Edge pending:
  - On a stable 0->1 transition with edge_mask[i]=1, edge_pend[i] <= 1.
  - Set and W1C clear on the same cycle: set wins.
  - Clearing edge_mask does not clear pending flags that are already set.
- Tick:
  - tick_cnt counts 0..TICK_DIV-1 and wraps. At wrap, tick_pend <= 1.
  - Set/clear collision: set wins.
  - Writes do not reset tick_cnt.
- Interrupt:
  - interrupt <= (tick_en & tick_pend) | (edge_en & |(edge_pend & edge_mask)).
  - Registered, so it lags its cause by 1 cycle.
  - Level output: it stays high until the ISR clears the pending flag(s).
- Reset mid-debounce or mid-tick: all in-flight state is discarded.

Optional Feature:
MCU_IO_TICK_EN
- Defined: tick counter and tick_pend are present as described above.
- Undefined: no tick logic is synthesised. Status bit0 reads 0, W1C to it is ignored, tick_en is stored but has no effect.

Decomposition:
- Package mcu_io_pkg holds:
  - Port ID constants: IO_ID_OUT_BASE=0x00, IO_ID_IN=0x10, IO_ID_EDGE=0x11, IO_ID_STAT=0x12, IO_ID_IRQEN=0x13, IO_ID_EMASK=0x14.
  - irq_en bit indices.
- Sub-module io_debounce (parameter DEB_CNT): one bit containing synchroniser, counter and stable output. It is instantiated N_IN times in a generate loop.

Test Plan:
All scenarios use the bench configuration DEB_CNT=4, TICK_DIV=10, N_OUT=4, N_IN=8.
- Out-register writes:
  - Stimulus: write 0xA5 to 0x01, write 0x3C to 0x07.
  - Response: out_ports[15:8]=0xA5 on the next edge; 0x3C is ignored, all other bytes stay 0x00; reading 0x07 returns 0x00.
- Debounce timing:
  - Stimulus: pins_in[0] high for 3 cycles, then low; later pins_in[0] held high.
  - Response: 3-cycle pulse gives no change on stable; held high, reading 0x10 shows bit0=1 exactly 6 cycles after the pin change (+1 cycle read latency).
- Edge interrupt:
  - Stimulus: edge_mask=0x01, irq_en=0x02, debounced rise on pins_in[0].
  - Response: 0x11 reads 0x01 and interrupt=1; W1C 0x01 to 0x11 drops interrupt 1 cycle later.
- Set/clear collision:
  - Stimulus: W1C to 0x11 on the same cycle as a new debounced rise.
  - Response: edge_pend[0] remains 1.
- Tick (MCU_IO_TICK_EN defined):
  - Stimulus: irq_en=0x01.
  - Response: interrupt rises 1 cycle after tick_cnt wraps (every 10 cycles); without the macro, 0x12 reads 0x00 and interrupt never rises.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst between clock edges while a debounce count is in progress and interrupt=1.
  - Response: all outputs return to reset values immediately, without waiting for a clock edge.
